// File: rtl/sp_ram_bist_pkg.sv
// Shared types and constants for the March C- single-port RAM BIST.
// Element table: address direction, read background and write background per march element.
package sp_ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CHECK,
        DONE
    } state_t;

    // Background selectors, replicated across the data width by the user.
    localparam logic BG0 = 1'b0;
    localparam logic BG1 = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    typedef struct packed {
        logic down;
        logic has_read;
        logic read_bg;
        logic has_write;
        logic write_bg;
    } elem_t;

    function automatic elem_t elem_info(input logic [2:0] e);
        elem_t info;
        info = '0;
        case (e)
            E0:      info = '{down: DIR_UP,   has_read: 1'b0, read_bg: BG0, has_write: 1'b1, write_bg: BG0};
            E1:      info = '{down: DIR_UP,   has_read: 1'b1, read_bg: BG0, has_write: 1'b1, write_bg: BG1};
            E2:      info = '{down: DIR_UP,   has_read: 1'b1, read_bg: BG1, has_write: 1'b1, write_bg: BG0};
            E3:      info = '{down: DIR_DOWN, has_read: 1'b1, read_bg: BG0, has_write: 1'b1, write_bg: BG1};
            E4:      info = '{down: DIR_DOWN, has_read: 1'b1, read_bg: BG1, has_write: 1'b1, write_bg: BG0};
            E5:      info = '{down: DIR_UP,   has_read: 1'b1, read_bg: BG0, has_write: 1'b0, write_bg: BG0};
            default: info = '0;
        endcase
        return info;
    endfunction

    function automatic logic elem_down(input logic [2:0] e);
        elem_t info;
        info = elem_info(e);
        return info.down;
    endfunction

endpackage

// File: rtl/sp_ram_bist_if.sv
// RAM-side bus between the BIST (master) and the single-port RAM (slave).
interface sp_ram_bist_if #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
);

    logic                     ram_en;
    logic                     ram_w_r;
    logic [ADDRESS_WIDTH-1:0] ram_add;
    logic [DATA_WIDTH-1:0]    ram_data_in;
    logic [DATA_WIDTH-1:0]    ram_data_out;

    modport master (
        output ram_en,
        output ram_w_r,
        output ram_add,
        output ram_data_in,
        input  ram_data_out
    );

    modport slave (
        input  ram_en,
        input  ram_w_r,
        input  ram_add,
        input  ram_data_in,
        output ram_data_out
    );

endinterface

// File: rtl/sp_ram_bist_addr_gen.sv
// Up/down address counter for the march elements, loadable to 0 or DEPTH-1,
// with a terminal-count flag for the current direction.
module sp_ram_bist_addr_gen #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DEPTH         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     load_top,
    input  logic                     step,
    input  logic                     down,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     last
);

    localparam logic [ADDRESS_WIDTH-1:0] TOP = ADDRESS_WIDTH'(DEPTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_top ? TOP : '0;
        end else if (step) begin
            addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
    end

    assign last = down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/sp_ram_bist.sv
// March C- BIST controller for a single-port RAM with one-cycle registered read data.
// Stops at the first mismatch and reports its address and march element.
module sp_ram_bist
    import sp_ram_bist_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ADDRESS_WIDTH-1:0] fail_add,
    output logic [2:0]               fail_elem,
    sp_ram_bist_if.master            ram
);

    state_t                   state;
    logic [2:0]               elem;
    elem_t                    cur;
    logic                     next_down;
    logic [DATA_WIDTH-1:0]    expected;
    logic                     mismatch;

    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     addr_last;
    logic                     addr_load;
    logic                     addr_load_top;
    logic                     addr_step;

    always_comb begin
        cur       = elem_info(elem);
        next_down = elem_down(elem + 3'd1);
        expected  = {DATA_WIDTH{cur.read_bg}};
        // Case-inequality so that undriven or unknown read bits count as a mismatch.
        mismatch  = (ram.ram_data_out !== expected);
    end

    always_comb begin
        addr_load     = 1'b0;
        addr_load_top = 1'b0;
        addr_step     = 1'b0;
        case (state)
            IDLE, DONE: begin
                addr_load = start;
            end
            WRITE: begin
                if (addr_last) begin
                    addr_load     = 1'b1;
                    addr_load_top = next_down;
                end else begin
                    addr_step = 1'b1;
                end
            end
            RD_CHECK: begin
                if (!mismatch && !cur.has_write && !addr_last) begin
                    addr_step = 1'b1;
                end
            end
            default: begin
                addr_load = 1'b0;
            end
        endcase
    end

    sp_ram_bist_addr_gen #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DEPTH         (DEPTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (addr_load),
        .load_top (addr_load_top),
        .step     (addr_step),
        .down     (cur.down),
        .addr     (addr),
        .last     (addr_last)
    );

    assign ram.ram_add = addr;

    // RAM strobes are set on the transition into each state so they come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            elem            <= E0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_add        <= '0;
            fail_elem       <= '0;
            ram.ram_en      <= 1'b0;
            ram.ram_w_r     <= 1'b0;
            ram.ram_data_in <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= WRITE;
                        elem            <= E0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        fail_add        <= '0;
                        fail_elem       <= '0;
                        ram.ram_en      <= 1'b1;
                        ram.ram_w_r     <= 1'b1;
                        ram.ram_data_in <= {DATA_WIDTH{BG0}};
                    end
                end
                WRITE: begin
                    if (addr_last) begin
                        elem        <= elem + 3'd1;
                        state       <= RD_ISSUE;
                        ram.ram_w_r <= 1'b0;
                    end else if (cur.has_read) begin
                        state       <= RD_ISSUE;
                        ram.ram_w_r <= 1'b0;
                    end
                end
                RD_ISSUE: begin
                    state <= RD_CHECK;
                end
                RD_CHECK: begin
                    if (mismatch) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= 1'b0;
                        fail_add   <= addr;
                        fail_elem  <= elem;
                        ram.ram_en <= 1'b0;
                    end else if (cur.has_write) begin
                        state           <= WRITE;
                        ram.ram_w_r     <= 1'b1;
                        ram.ram_data_in <= {DATA_WIDTH{cur.write_bg}};
                    end else if (addr_last) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= 1'b1;
                        ram.ram_en <= 1'b0;
                    end else begin
                        state <= RD_ISSUE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
